// File: rtl/i2c_reg_slave.sv
// I2C register target: NUM_REGS x 8-bit bank behind a byte pointer, write [addr+W][ptr][data...], read [addr+R][data...].
// Define I2C_REG_SLAVE_GENERAL_CALL_EN to ACK general call (0x00+W) with reset command 0x06.
`timescale 1ns/1ps
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         NUM_REGS   = 4,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  debug_addr_match,
    output logic [3:0]            debug_state
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_RX_DEV_ADDR  = 4'd1,
        S_DEV_ADDR_ACK = 4'd2,
        S_RX_PTR       = 4'd3,
        S_PTR_ACK      = 4'd4,
        S_RX_DATA      = 4'd5,
        S_RX_DATA_ACK  = 4'd6,
        S_TX_DATA      = 4'd7,
        S_TX_ACK_CHK   = 4'd8,
        S_WAIT_STOP    = 4'd9
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REGS - 1);
    localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);

    state_t                state_q, state_d;
    logic [2:0]            scl_sync_q, sda_sync_q;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            tx_q, tx_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  phase_q, phase_d;
    logic                  match_q, match_d;
    logic                  rw_q, rw_d;
    logic                  gc_q, gc_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]      wr_index_q, wr_index_d;

    logic             scl_rise, scl_fall, scl_high, start_det, stop_det, sda_s;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       cur_byte;

    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign scl_high  = scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_high & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_high & ~sda_sync_q[2] & sda_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign next_ptr  = (ptr_q == LAST_IDX) ? '0 : ptr_q + PTR_W'(1);
    assign cur_byte  = regs_q[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_oe_d    = sda_oe_q;
        phase_d     = phase_q;
        match_d     = match_q;
        rw_d        = rw_q;
        gc_d        = gc_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;

        if (stop_det && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            match_d   = 1'b0;
            phase_d   = 1'b0;
            gc_d      = 1'b0;
        end else if (start_det) begin
            state_d   = S_RX_DEV_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            match_d   = 1'b0;
            phase_d   = 1'b0;
            gc_d      = 1'b0;
        end else begin
            case (state_q)
                S_RX_DEV_ADDR, S_RX_PTR, S_RX_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == S_RX_DEV_ADDR) begin
`ifdef I2C_REG_SLAVE_GENERAL_CALL_EN
                                gc_d = (shift_d == 8'h00);
`else
                                gc_d = 1'b0;
`endif
                                match_d = (shift_d[7:1] == SLAVE_ADDR) || gc_d;
                                rw_d    = shift_d[0];
                                state_d = S_DEV_ADDR_ACK;
                            end else if (state_q == S_RX_PTR) begin
                                state_d = S_PTR_ACK;
                            end else begin
                                state_d = S_RX_DATA_ACK;
                            end
                        end
                    end
                end
                S_DEV_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            if (match_q) begin
                                sda_oe_d = 1'b1;
                                phase_d  = 1'b1;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_WAIT_STOP;
                            end
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q) begin
                                tx_d     = cur_byte;
                                sda_oe_d = ~cur_byte[7];
                                state_d  = S_TX_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_RX_PTR;
                            end
                        end
                    end
                end
                S_PTR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            if (gc_q ? (shift_q == 8'h06) : (shift_q < NUM_REGS_B)) begin
                                sda_oe_d = 1'b1;
                                phase_d  = 1'b1;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_WAIT_STOP;
                            end
                        end else begin
                            phase_d  = 1'b0;
                            sda_oe_d = 1'b0;
                            // General-call reset clears the bank silently, no strobe
                            if (gc_q) begin
                                regs_d  = '0;
                                ptr_d   = '0;
                                state_d = S_WAIT_STOP;
                            end else begin
                                ptr_d   = shift_q[PTR_W-1:0];
                                state_d = S_RX_DATA;
                            end
                        end
                    end
                end
                S_RX_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d                     = 1'b0;
                            sda_oe_d                    = 1'b0;
                            regs_d[{ptr_q, 3'b000} +: 8] = shift_q;
                            wr_strobe_d                 = 1'b1;
                            wr_index_d                  = ptr_q;
                            ptr_d                       = next_ptr;
                            state_d                     = S_RX_DATA;
                        end
                    end
                end
                S_TX_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = S_TX_ACK_CHK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_oe_d  = ~tx_q[6];
                        end
                    end
                end
                S_TX_ACK_CHK: begin
                    if (!phase_q && scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = next_ptr;
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end else if (phase_q && scl_fall) begin
                        phase_d  = 1'b0;
                        tx_d     = cur_byte;
                        sda_oe_d = ~cur_byte[7];
                        state_d  = S_TX_DATA;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            tx_q        <= '0;
            bit_cnt_q   <= '0;
            ptr_q       <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            phase_q     <= 1'b0;
            match_q     <= 1'b0;
            rw_q        <= 1'b0;
            gc_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            scl_sync_q  <= {scl_sync_q[1:0], scl};
            sda_sync_q  <= {sda_sync_q[1:0], sda};
            state_q     <= state_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            sda_oe_q    <= sda_oe_d;
            phase_q     <= phase_d;
            match_q     <= match_d;
            rw_q        <= rw_d;
            gc_q        <= gc_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    assign sda              = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_out          = regs_q;
    assign wr_strobe        = wr_strobe_q;
    assign wr_index         = wr_index_q;
    assign debug_addr_match = match_q;
    assign debug_state      = state_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, strobe scoreboard plus directed bus/register checks.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
    localparam int NUM_REGS = 4;
    localparam int PTR_W    = 2;
    localparam int Q        = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic m_low = 1'b0;
    wire  sda_w;

    logic [NUM_REGS*8-1:0] reg_out;
    logic                  wr_strobe;
    logic [PTR_W-1:0]      wr_index;
    logic                  debug_addr_match;
    logic [3:0]            debug_state;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    i2c_reg_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(NUM_REGS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .scl              (scl_m),
        .sda              (sda_w),
        .reg_out          (reg_out),
        .wr_strobe        (wr_strobe),
        .wr_index         (wr_index),
        .debug_addr_match (debug_addr_match),
        .debug_state      (debug_state)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [PTR_W-1:0] idx;
        logic [7:0]       data;
    } wr_exp_t;
    wr_exp_t exp_q[$];
    wr_exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next queued write
    initial forever begin
        @(negedge clk);
        if (wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_strobe: got index %0d, expected no write", wr_index);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_index", 32'(wr_index), 32'(mon_e.idx));
                check("strobe_data", 32'(reg_out[int'(mon_e.idx)*8 +: 8]), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic i2c_start();
        m_low = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        m_low = 1'b1; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        m_low = 1'b0; #(Q);
    endtask

    task automatic wr_bit(input logic b);
        m_low = ~b;   #(Q);
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic rd_bit(output logic b);
        m_low = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_w;    #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(~ack);
    endtask

    logic       ack;
    logic       bit_v;
    logic [7:0] rd;

    initial begin
        #(Q);
        check("rst_reg_out", reg_out, 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_index", 32'(wr_index), 32'h0);
        check("rst_match", 32'(debug_addr_match), 32'h0);
        check("rst_state", 32'(debug_state), 32'h0);
        check("rst_sda", 32'(sda_w), 32'h1);
        rst_n = 1'b1;
        #(2*Q);

        // Single write to reg1
        i2c_start();
        wr_byte(8'hAA, ack); check("t1_addr_ack", 32'(ack), 32'h1);
        check("t1_match", 32'(debug_addr_match), 32'h1);
        wr_byte(8'h01, ack); check("t1_ptr_ack", 32'(ack), 32'h1);
        exp_q.push_back('{idx: 2'd1, data: 8'h3C});
        wr_byte(8'h3C, ack); check("t1_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("t1_state_idle", 32'(debug_state), 32'h0);
        check("t1_match_clr", 32'(debug_addr_match), 32'h0);
        check("t1_reg_out", reg_out, 32'h0000_3C00);

        // Pointer wrap 3 -> 0
        i2c_start();
        wr_byte(8'hAA, ack); check("t2_addr_ack", 32'(ack), 32'h1);
        wr_byte(8'h03, ack); check("t2_ptr_ack", 32'(ack), 32'h1);
        exp_q.push_back('{idx: 2'd3, data: 8'h11});
        exp_q.push_back('{idx: 2'd0, data: 8'h22});
        wr_byte(8'h11, ack); check("t2_d0_ack", 32'(ack), 32'h1);
        wr_byte(8'h22, ack); check("t2_d1_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("t2_reg_out", reg_out, 32'h1100_3C22);

        i2c_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h02, ack);
        exp_q.push_back('{idx: 2'd2, data: 8'hC3});
        wr_byte(8'hC3, ack); check("t2b_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("t2b_reg_out", reg_out, 32'h11C3_3C22);

        // Set pointer, repeated START, read two bytes
        i2c_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h02, ack); check("t3_ptr_ack", 32'(ack), 32'h1);
        i2c_start();
        wr_byte(8'hAB, ack); check("t3_raddr_ack", 32'(ack), 32'h1);
        rd_byte(1'b1, rd); check("t3_rd0", 32'(rd), 32'hC3);
        rd_byte(1'b0, rd); check("t3_rd1", 32'(rd), 32'h11);
        check("t3_sda_released", 32'(sda_w), 32'h1);
        check("t3_wait_stop", 32'(debug_state), 32'h9);
        i2c_stop();
        check("t3_state_idle", 32'(debug_state), 32'h0);

        // Wrong address
        i2c_start();
        wr_byte(8'hA8, ack); check("t4_addr_nack", 32'(ack), 32'h0);
        check("t4_wait_stop", 32'(debug_state), 32'h9);
        check("t4_match", 32'(debug_addr_match), 32'h0);
        wr_byte(8'h55, ack); check("t4_data_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("t4_state_idle", 32'(debug_state), 32'h0);
        check("t4_reg_out", reg_out, 32'h11C3_3C22);

        // Out-of-range pointer
        i2c_start();
        wr_byte(8'hAA, ack); check("t5_addr_ack", 32'(ack), 32'h1);
        wr_byte(8'h07, ack); check("t5_ptr_nack", 32'(ack), 32'h0);
        wr_byte(8'h99, ack); check("t5_data_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("t5_reg_out", reg_out, 32'h11C3_3C22);

        // Reset while the target is driving a read bit (ptr=3, reg3=0x11)
        i2c_start();
        wr_byte(8'hAB, ack); check("t6_raddr_ack", 32'(ack), 32'h1);
        rd_bit(bit_v); check("t6_bit7", 32'(bit_v), 32'h0);
        rd_bit(bit_v); check("t6_bit6", 32'(bit_v), 32'h0);
        check("t6_sda_driven", 32'(sda_w), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_sda_released", 32'(sda_w), 32'h1);
        check("t6_reg_out_clr", reg_out, 32'h0);
        check("t6_state", 32'(debug_state), 32'h0);
        scl_m = 1'b1;
        m_low = 1'b0;
        #(Q);
        rst_n = 1'b1;
        #(Q);
        i2c_start();
        wr_byte(8'hAA, ack); check("t6_w_addr_ack", 32'(ack), 32'h1);
        wr_byte(8'h01, ack);
        exp_q.push_back('{idx: 2'd1, data: 8'h5A});
        wr_byte(8'h5A, ack); check("t6_w_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("t6_reg_out", reg_out, 32'h0000_5A00);

        // Burst write through the wrap, then read back across the wrap
        i2c_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h00, ack);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{idx: 2'(i % NUM_REGS), data: 8'(8'h10 * (i + 1))});
            wr_byte(8'(8'h10 * (i + 1)), ack);
            check("t7_burst_ack", 32'(ack), 32'h1);
        end
        i2c_stop();
        check("t7_reg_out", reg_out, 32'h4030_2050);
        i2c_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h03, ack);
        i2c_start();
        wr_byte(8'hAB, ack);
        rd_byte(1'b1, rd); check("t7_rd_reg3", 32'(rd), 32'h40);
        rd_byte(1'b0, rd); check("t7_rd_reg0", 32'(rd), 32'h50);
        i2c_stop();

        // Data byte aborted mid-way commits nothing
        i2c_start();
        wr_byte(8'hAA, ack);
        wr_byte(8'h01, ack);
        for (int i = 0; i < 4; i++) wr_bit(1'b1);
        i2c_stop();
        check("t8_reg_out", reg_out, 32'h4030_2050);
        check("t8_state_idle", 32'(debug_state), 32'h0);

        // General call
        i2c_start();
        wr_byte(8'h00, ack);
`ifdef I2C_REG_SLAVE_GENERAL_CALL_EN
        check("t9_gc_ack", 32'(ack), 32'h1);
        check("t9_gc_match", 32'(debug_addr_match), 32'h1);
        wr_byte(8'h06, ack); check("t9_gc_cmd_ack", 32'(ack), 32'h1);
        i2c_stop();
        check("t9_reg_out", reg_out, 32'h0);
`else
        check("t9_gc_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("t9_reg_out", reg_out, 32'h4030_2050);
`endif

        #(2*Q);
        check("pending_strobes", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
Parametrised I2C target with a bank of NUM_REGS 8-bit registers, a register pointer, and read/write support.
- Write: [START][addr+W][ptr][data...][STOP].
- Read: [START][addr+R][data...] until the master NACKs. Repeated START is supported.
- Drives general-purpose outputs (LEDs, mode bits) on the board I2C bus, alongside the existing single-byte LED target.

Parameters:
SLAVE_ADDR, 7'h55, 7-bit target address
NUM_REGS, 4, number of 8-bit registers (2..16)
PTR_W, $clog2(NUM_REGS), pointer width (derived, do not override)

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
scl  in  1  I2C clock from master
sda  inout  1  I2C data; driven only low, else 'z'
reg_out  out  NUM_REGS*8  register bank, reg i at [8i+7:8i]
wr_strobe  out  1  one-clk pulse per committed register write
wr_index  out  PTR_W  index of register written with wr_strobe
debug_addr_match  out  1  address matched in current transaction
debug_state  out  4  FSM state encoding

Behaviour:
- Reset values: all registers 0; pointer 0; sda released; wr_strobe 0; wr_index 0; debug_addr_match 0; state IDLE.
- Input sync: scl and sda pass through 3-flop synchronisers.
  - Edges come from stages [2:1].
  - START = sda falls while scl high. STOP = sda rises while scl high. Both are evaluated on the synchronised signals.
- Priority, highest first: STOP, then START, then the per-state logic.
  - STOP in any non-IDLE state: go to IDLE, release sda, clear bit count and match.
  - START in any state, including mid-byte (repeated START): go to RX_DEV_ADDR, bit count 0, release sda. The pointer is retained.
- IDLE: wait for START.
- RX_DEV_ADDR:
  - Shift sda on each scl rise, MSB first.
  - After the 8th bit, match = (addr[7:1] == SLAVE_ADDR); R/W bit is latched.
  - Go to DEV_ADDR_ACK.
- DEV_ADDR_ACK:
  - On no match: release sda, go to WAIT_STOP.
  - On match: drive 0 from the next scl fall; release at the following scl fall.
  - At that fall, W goes to RX_PTR. R goes to TX_DATA, and the MSB of reg[ptr] is driven in the same cycle sda is released.
- RX_PTR: receive 8 bits, then go to PTR_ACK.
  - Value < NUM_REGS: ACK, load pointer, go to RX_DATA.
  - Otherwise: NACK (sda released), pointer unchanged, go to WAIT_STOP.
- RX_DATA: receive 8 bits, then go to RX_DATA_ACK.
- RX_DATA_ACK:
  - ACK as above.
  - At the scl fall ending the ACK: reg[ptr] <= byte; wr_strobe = 1 for one clk; wr_index = ptr.
  - Pointer increments, wrapping NUM_REGS-1 to 0. Go to RX_DATA.
  - Latency: reg_out updates 1 clk after the synchronised scl fall.
- TX_DATA:
  - Change sda only on scl falls. A 1 bit means released, not driven high.
  - After the 8th bit's scl fall, release sda and go to TX_ACK_CHK.
- TX_ACK_CHK: sample sda on scl rise.
  - 0 (ACK): pointer increments with wrap; on the next scl fall, drive the MSB of the new reg[ptr]; go to TX_DATA.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: sda released; exit only via STOP or START.
- Reset mid-transaction: sda released immediately (asynchronous); bank cleared.
- A transaction with no data byte, or one aborted mid-byte, commits nothing.

Optional Feature:
Macro: I2C_REG_SLAVE_GENERAL_CALL_EN
- Defined:
  - Address 0x00 with W is ACKed.
  - If the next byte is 0x06, it is ACKed, then all registers and the pointer are cleared at that ACK's scl fall. wr_strobe does not fire.
  - Any other byte is NACKed; go to WAIT_STOP.
  - debug_addr_match is 1 during a general call.
- Undefined: address 0x00 is NACKed like any mismatch.

Test Plan:
- Write 0xAA,0x01,0x3C,STOP -> reg1=0x3C; one wr_strobe with wr_index=1; ACKs at 9th clocks of all three bytes.
- Write 0xAA,0x03,0x11,0x22 (NUM_REGS=4) -> reg3=0x11, reg0=0x22 (wrap); two strobes, indices 3 then 0.
- Write 0xAA,0x02 then repeated START, 0xAB, read 2 bytes with ACK then NACK -> returns reg2, reg3; sda released after NACK; STOP returns FSM to IDLE.
- Address 0xA8 (0x54+W) -> no ACK (sda high at 9th clock); registers unchanged; WAIT_STOP until STOP.
- Write 0xAA,0x07 (out of range) -> pointer byte NACKed; following data byte ignored; no strobe.
- rst_n low mid-data-byte -> sda 'z' immediately; reg_out=0; next full write transaction succeeds.
